spi_reg_writer: RTL

// - SPI peripheral (mode 0, MSB first) that decodes 16-bit host frames and writes the 5-entry

---
 rtl/spi_reg_writer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 peripheral (MSB first) that decodes 16-bit host frames
// and writes the five-entry register file driving the PWM peripheral.
// Frame layout: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
// Optional read-back is enabled by defining the macro SPI_READBACK_EN; without it
// cipo is tied low and read frames are dropped.
module spi_reg_writer #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [4:0] BIT_CNT_FULL = 5'd16;
  localparam logic [4:0] BIT_CNT_SAT  = 5'd17;
  localparam logic [6:0] NUM_REGS     = 7'd5;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;

  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;
  logic copi_s;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        wr_en;

  logic [7:0] reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;

  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       addr_ok;

  // Synchronizers for the three asynchronous pins. The chip-select chain clears to 0
  // so a frame already running when reset releases never shows a falling edge and is
  // therefore ignored until the host starts a fresh frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    end
  end

  assign sclk_rise =  sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
  assign ncs_fall  = ~ncs_sync_q[SYNC_STAGES-2]  &  ncs_sync_q[SYNC_STAGES-1];
  assign ncs_rise  =  ncs_sync_q[SYNC_STAGES-2]  & ~ncs_sync_q[SYNC_STAGES-1];
  // COPI is taken one stage later than SCLK; it is long stable around the rising
  // edge because the host changes it on the falling edge.
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];

  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign addr_ok    = (frame_addr <= MAX_ADDR) && (frame_addr < NUM_REGS);

  // FSM state, bit counter and receive shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: capture bits while selected, then qualify the frame on deselect.
  // A new frame start seen during COMMIT goes straight to SHIFT, so a one-clock
  // chip-select gap between back-to-back frames does not lose the second frame.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          if (bit_cnt_q != BIT_CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        if (ncs_rise) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        wr_en   = (bit_cnt_q == BIT_CNT_FULL) && shift_q[15] && addr_ok;
        state_d = IDLE;
        if (ncs_fall) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register file: written only by a qualified frame, otherwise holds indefinitely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg0_q <= 8'h00;
      reg1_q <= 8'h00;
      reg2_q <= 8'h00;
      reg3_q <= 8'h00;
      reg4_q <= 8'h00;
    end else if (wr_en) begin
      case (frame_addr[2:0])
        3'd0:    reg0_q <= frame_data;
        3'd1:    reg1_q <= frame_data;
        3'd2:    reg2_q <= frame_data;
        3'd3:    reg3_q <= frame_data;
        3'd4:    reg4_q <= frame_data;
        default: reg0_q <= reg0_q;
      endcase
    end
  end

  assign en_reg_out_7_0  = reg0_q;
  assign en_reg_out_15_8 = reg1_q;
  assign en_reg_pwm_7_0  = reg2_q;
  assign en_reg_pwm_15_8 = reg3_q;
  assign pwm_duty_cycle  = reg4_q;

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic       ncs_s;
  logic [7:0] rd_data;
  logic [7:0] tx_q;
  logic       tx_valid_q;
  logic       tx_loaded_q;
  logic [6:0] rd_addr;
  logic       rd_addr_ok;

  assign sclk_fall  = ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s      = ncs_sync_q[SYNC_STAGES-2];
  // After eight bits the low byte of the shift register holds R/W and the address.
  assign rd_addr    = shift_q[6:0];
  assign rd_addr_ok = (rd_addr <= MAX_ADDR) && (rd_addr < NUM_REGS);

  // Read mux selecting the register addressed by the first byte of the frame.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr[2:0])
      3'd0:    rd_data = reg0_q;
      3'd1:    rd_data = reg1_q;
      3'd2:    rd_data = reg2_q;
      3'd3:    rd_data = reg3_q;
      3'd4:    rd_data = reg4_q;
      default: rd_data = 8'h00;
    endcase
  end

  // Transmit shifter: loaded once per frame after the address byte, then advanced on
  // the falling edges following bits 9..15 so the host samples bits 7..0 on rises 9..16.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q        <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_loaded_q <= 1'b0;
    end else if (state_q != SHIFT) begin
      tx_q        <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_loaded_q <= 1'b0;
    end else if (!tx_loaded_q && (bit_cnt_q == 5'd8)) begin
      tx_loaded_q <= 1'b1;
      if (!shift_q[7] && rd_addr_ok) begin
        tx_q       <= rd_data;
        tx_valid_q <= 1'b1;
      end
    end else if (tx_loaded_q && sclk_fall && (bit_cnt_q > 5'd8)) begin
      tx_q <= {tx_q[6:0], 1'b0};
    end
  end

  assign cipo = tx_valid_q & tx_q[7] & ~ncs_s;
`else
  assign cipo = 1'b0;
`endif

endmodule
